// File: rtl/door_pkg.sv
// Shared constants and state encoding for the door security path.
// Used by keypad_code_entry (producer of passin/enter) and door_security.
package door_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned PASS_W  = 12;
    localparam int unsigned DIGITS  = PASS_W / DIGIT_W;
    localparam int unsigned CNT_W   = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SUBMIT  = 2'd2,
        LOCKED  = 2'd3
    } entry_state_e;

endpackage : door_pkg

// File: rtl/keypad_code_entry_if.sv
// Keypad / door_security bus seen by keypad_code_entry.
//   key_valid/key_data/key_enter/key_clear : debounced key strobe from scanner
//   alarm_in                               : lockout request from door_security
//   passin/enter                           : submitted code and submit strobe
//   digit_cnt/entry_err/locked             : entry status
// slave = keypad_code_entry, master = the surrounding logic (or a bench).
interface keypad_code_entry_if;
    import door_pkg::*;

    logic               key_valid;
    logic [DIGIT_W-1:0] key_data;
    logic               key_enter;
    logic               key_clear;
    logic               alarm_in;
    logic [PASS_W-1:0]  passin;
    logic               enter;
    logic [CNT_W-1:0]   digit_cnt;
    logic               entry_err;
    logic               locked;

    modport master (
        output key_valid, key_data, key_enter, key_clear, alarm_in,
        input  passin, enter, digit_cnt, entry_err, locked
    );

    modport slave (
        input  key_valid, key_data, key_enter, key_clear, alarm_in,
        output passin, enter, digit_cnt, entry_err, locked
    );

endinterface : keypad_code_entry_if

// File: rtl/keypad_code_entry_timer.sv
// entry_timer: idle counter that saturates at TIMEOUT_CYC-1.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : force count to 0 (has priority over en_i)
//   en_i       : count one step
//   expired_o  : registered, high while count == TIMEOUT_CYC-1
module entry_timer #(
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] cnt_q, cnt_d;
    logic          expired_q, expired_d;

    // Next count; saturates so expired stays asserted until cleared.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + TW'(1);
        end
        expired_d = (cnt_d == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign expired_o = expired_q;

endmodule : entry_timer

// File: rtl/keypad_code_entry.sv
// keypad_code_entry: assembles keypad hex digits into a PASS_W code and
// submits it to door_security with a one-cycle enter strobe. Locks out all
// keys while alarm_in is high.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   kp    : keypad/door bus (slave side), see keypad_code_entry_if
module keypad_code_entry
    import door_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                reset,
    keypad_code_entry_if.slave  kp
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DIGITS);

    entry_state_e      state_q, state_d;
    logic [PASS_W-1:0] shreg_q, shreg_d;
    logic [PASS_W-1:0] passin_q, passin_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              enter_q, enter_d;
    logic              err_q, err_d;
    logic              locked_q, locked_d;

    logic timer_clr, timer_en, timer_expired;
    logic is_clear, is_enter, is_digit;

    // CLEAR wins over ENTER when both qualifiers are set.
    assign is_clear = kp.key_valid & kp.key_clear;
    assign is_enter = kp.key_valid & kp.key_enter & ~kp.key_clear;
    assign is_digit = kp.key_valid & ~kp.key_enter & ~kp.key_clear;

    entry_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk       (clk),
        .rst_n     (reset),
        .clr_i     (timer_clr),
        .en_i      (timer_en),
        .expired_o (timer_expired)
    );

    // Next-state and output decode; alarm_in overrides every key.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        passin_d  = passin_q;
        cnt_d     = cnt_q;
        enter_d   = 1'b0;
        err_d     = 1'b0;
        timer_clr = 1'b0;
        timer_en  = 1'b0;

        if (kp.alarm_in) begin
            state_d   = LOCKED;
            shreg_d   = '0;
            cnt_d     = '0;
            timer_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    timer_clr = 1'b1;
                    if (is_digit) begin
                        shreg_d = PASS_W'(kp.key_data);
                        cnt_d   = CNT_W'(1);
                        state_d = COLLECT;
                    end else if (is_enter) begin
                        err_d = 1'b1;
                    end
                end

                COLLECT: begin
                    timer_en = 1'b1;
                    if (is_clear) begin
                        shreg_d   = '0;
                        cnt_d     = '0;
                        state_d   = IDLE;
                        timer_clr = 1'b1;
                    end else if (is_enter) begin
                        timer_clr = 1'b1;
                        shreg_d   = '0;
                        cnt_d     = '0;
                        if (cnt_q == FULL) begin
                            passin_d = shreg_q;
                            enter_d  = 1'b1;
                            state_d  = SUBMIT;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (is_digit) begin
                        timer_clr = 1'b1;
                        if (cnt_q < FULL) begin
                            shreg_d = {shreg_q[PASS_W-DIGIT_W-1:0], kp.key_data};
                            cnt_d   = cnt_q + CNT_W'(1);
                        end else begin
                            // Code already complete: drop the extra digit.
                            err_d = 1'b1;
                        end
                    end else if (timer_expired) begin
                        err_d     = 1'b1;
                        shreg_d   = '0;
                        cnt_d     = '0;
                        state_d   = IDLE;
                        timer_clr = 1'b1;
                    end
                end

                SUBMIT: begin
                    // Keys landing here are ignored; passin stays held.
                    timer_clr = 1'b1;
                    shreg_d   = '0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end

                LOCKED: begin
                    // Only reached here with alarm_in low: release lockout.
                    timer_clr = 1'b1;
                    shreg_d   = '0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end

                default: begin
                    timer_clr = 1'b1;
                    shreg_d   = '0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            passin_q <= '0;
            cnt_q    <= '0;
            enter_q  <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            passin_q <= passin_d;
            cnt_q    <= cnt_d;
            enter_q  <= enter_d;
            err_q    <= err_d;
            locked_q <= locked_d;
        end
    end

    assign kp.passin    = passin_q;
    assign kp.enter     = enter_q;
    assign kp.digit_cnt = cnt_q;
    assign kp.entry_err = err_q;
    assign kp.locked    = locked_q;

endmodule : keypad_code_entry

// File: tb/tb_keypad_code_entry.sv
// Directed bench for keypad_code_entry: code entry, short/overlong codes,
// idle timeout, alarm lockout, async reset and CLEAR+ENTER precedence.
module tb_keypad_code_entry;

    localparam int unsigned TIMEOUT_CYC = 1000;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    keypad_code_entry_if kif ();

    keypad_code_entry #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .kp    (kif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One key strobe for one cycle; returns 1 time unit after the sampling edge.
    task automatic press(input logic [3:0] d, input logic e, input logic c);
        @(negedge clk);
        kif.key_valid = 1'b1;
        kif.key_data  = d;
        kif.key_enter = e;
        kif.key_clear = c;
        @(posedge clk);
        #1;
        kif.key_valid = 1'b0;
        kif.key_enter = 1'b0;
        kif.key_clear = 1'b0;
        kif.key_data  = 4'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        kif.key_valid = 1'b0; kif.key_data = 4'h0;
        kif.key_enter = 1'b0; kif.key_clear = 1'b0; kif.alarm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (kif.passin !== 12'h000) begin errors++; $display("FAIL reset_passin got=%h exp=000", kif.passin); end
        checks++; if (kif.enter !== 1'b0) begin errors++; $display("FAIL reset_enter got=%b exp=0", kif.enter); end
        checks++; if (kif.digit_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", kif.digit_cnt); end
        checks++; if (kif.entry_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", kif.entry_err); end
        checks++; if (kif.locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b exp=0", kif.locked); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_submit();
        logic [3:0] keys [3];
        keys[0] = 4'h0; keys[1] = 4'hA; keys[2] = 4'h8;
        for (int i = 0; i < 3; i++) begin
            press(keys[i], 1'b0, 1'b0);
            checks++; if (kif.digit_cnt !== 2'(i + 1)) begin errors++; $display("FAIL submit_cnt%0d got=%0d exp=%0d", i, kif.digit_cnt, i + 1); end
            checks++; if (kif.enter !== 1'b0) begin errors++; $display("FAIL submit_early_enter%0d got=%b exp=0", i, kif.enter); end
        end
        press(4'h0, 1'b1, 1'b0);
        checks++; if (kif.enter !== 1'b1) begin errors++; $display("FAIL submit_enter got=%b exp=1", kif.enter); end
        checks++; if (kif.passin !== 12'h0A8) begin errors++; $display("FAIL submit_passin got=%h exp=0a8", kif.passin); end
        checks++; if (kif.digit_cnt !== 2'd0) begin errors++; $display("FAIL submit_cnt_after got=%0d exp=0", kif.digit_cnt); end
        step();
        checks++; if (kif.enter !== 1'b0) begin errors++; $display("FAIL submit_enter_width got=%b exp=0", kif.enter); end
        checks++; if (kif.passin !== 12'h0A8) begin errors++; $display("FAIL submit_passin_hold got=%h exp=0a8", kif.passin); end
    endtask

    task automatic test_short_code();
        press(4'hF, 1'b0, 1'b0);
        press(4'hE, 1'b0, 1'b0);
        press(4'h0, 1'b1, 1'b0);
        checks++; if (kif.entry_err !== 1'b1) begin errors++; $display("FAIL short_err got=%b exp=1", kif.entry_err); end
        checks++; if (kif.enter !== 1'b0) begin errors++; $display("FAIL short_enter got=%b exp=0", kif.enter); end
        checks++; if (kif.passin !== 12'h0A8) begin errors++; $display("FAIL short_passin got=%h exp=0a8", kif.passin); end
        checks++; if (kif.digit_cnt !== 2'd0) begin errors++; $display("FAIL short_cnt got=%0d exp=0", kif.digit_cnt); end
        step();
        checks++; if (kif.entry_err !== 1'b0) begin errors++; $display("FAIL short_err_width got=%b exp=0", kif.entry_err); end
    endtask

    task automatic test_overflow();
        press(4'h1, 1'b0, 1'b0);
        press(4'h2, 1'b0, 1'b0);
        press(4'h3, 1'b0, 1'b0);
        press(4'h4, 1'b0, 1'b0);
        checks++; if (kif.entry_err !== 1'b1) begin errors++; $display("FAIL ovf_err got=%b exp=1", kif.entry_err); end
        checks++; if (kif.digit_cnt !== 2'd3) begin errors++; $display("FAIL ovf_cnt got=%0d exp=3", kif.digit_cnt); end
        press(4'h0, 1'b1, 1'b0);
        checks++; if (kif.enter !== 1'b1) begin errors++; $display("FAIL ovf_enter got=%b exp=1", kif.enter); end
        checks++; if (kif.passin !== 12'h123) begin errors++; $display("FAIL ovf_passin got=%h exp=123", kif.passin); end
        checks++; if (kif.entry_err !== 1'b0) begin errors++; $display("FAIL ovf_err_clr got=%b exp=0", kif.entry_err); end
        step();
        checks++; if (kif.enter !== 1'b0) begin errors++; $display("FAIL ovf_enter_width got=%b exp=0", kif.enter); end
    endtask

    task automatic test_timeout();
        press(4'hA, 1'b0, 1'b0);
        press(4'h9, 1'b0, 1'b0);
        for (int i = 0; i < int'(TIMEOUT_CYC) - 1; i++) step();
        checks++; if (kif.entry_err !== 1'b0) begin errors++; $display("FAIL tmo_early_err got=%b exp=0", kif.entry_err); end
        checks++; if (kif.digit_cnt !== 2'd2) begin errors++; $display("FAIL tmo_early_cnt got=%0d exp=2", kif.digit_cnt); end
        step();
        checks++; if (kif.entry_err !== 1'b1) begin errors++; $display("FAIL tmo_err got=%b exp=1", kif.entry_err); end
        checks++; if (kif.digit_cnt !== 2'd0) begin errors++; $display("FAIL tmo_cnt got=%0d exp=0", kif.digit_cnt); end
        press(4'hA, 1'b0, 1'b0);
        press(4'h8, 1'b0, 1'b0);
        press(4'hE, 1'b0, 1'b0);
        press(4'h0, 1'b1, 1'b0);
        checks++; if (kif.enter !== 1'b1) begin errors++; $display("FAIL tmo_next_enter got=%b exp=1", kif.enter); end
        checks++; if (kif.passin !== 12'hA8E) begin errors++; $display("FAIL tmo_next_passin got=%h exp=a8e", kif.passin); end
        step();
    endtask

    task automatic test_lockout();
        press(4'hA, 1'b0, 1'b0);
        press(4'h8, 1'b0, 1'b0);
        @(negedge clk);
        kif.alarm_in = 1'b1;
        step();
        checks++; if (kif.locked !== 1'b1) begin errors++; $display("FAIL lock_locked got=%b exp=1", kif.locked); end
        checks++; if (kif.digit_cnt !== 2'd0) begin errors++; $display("FAIL lock_cnt got=%0d exp=0", kif.digit_cnt); end
        press(4'h5, 1'b0, 1'b0);
        checks++; if (kif.digit_cnt !== 2'd0) begin errors++; $display("FAIL lock_digit_ignored got=%0d exp=0", kif.digit_cnt); end
        press(4'h0, 1'b1, 1'b0);
        checks++; if (kif.enter !== 1'b0) begin errors++; $display("FAIL lock_enter got=%b exp=0", kif.enter); end
        checks++; if (kif.entry_err !== 1'b0) begin errors++; $display("FAIL lock_err got=%b exp=0", kif.entry_err); end
        checks++; if (kif.passin !== 12'hA8E) begin errors++; $display("FAIL lock_passin got=%h exp=a8e", kif.passin); end
        @(negedge clk);
        kif.alarm_in = 1'b0;
        step();
        checks++; if (kif.locked !== 1'b0) begin errors++; $display("FAIL unlock_locked got=%b exp=0", kif.locked); end
        press(4'h0, 1'b0, 1'b0);
        press(4'hA, 1'b0, 1'b0);
        press(4'h8, 1'b0, 1'b0);
        press(4'h0, 1'b1, 1'b0);
        checks++; if (kif.enter !== 1'b1) begin errors++; $display("FAIL unlock_enter got=%b exp=1", kif.enter); end
        checks++; if (kif.passin !== 12'h0A8) begin errors++; $display("FAIL unlock_passin got=%h exp=0a8", kif.passin); end
        step();
    endtask

    task automatic test_async_reset();
        press(4'h0, 1'b0, 1'b0);
        checks++; if (kif.digit_cnt !== 2'd1) begin errors++; $display("FAIL arst_pre_cnt got=%0d exp=1", kif.digit_cnt); end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (kif.digit_cnt !== 2'd0) begin errors++; $display("FAIL arst_cnt got=%0d exp=0", kif.digit_cnt); end
        checks++; if (kif.passin !== 12'h000) begin errors++; $display("FAIL arst_passin got=%h exp=000", kif.passin); end
        checks++; if (kif.enter !== 1'b0 || kif.entry_err !== 1'b0 || kif.locked !== 1'b0) begin
            errors++; $display("FAIL arst_flags got=%b%b%b exp=000", kif.enter, kif.entry_err, kif.locked);
        end
        @(negedge clk);
        rst_n = 1'b1;
        press(4'h0, 1'b1, 1'b1);
        checks++; if (kif.entry_err !== 1'b0) begin errors++; $display("FAIL clrent_idle_err got=%b exp=0", kif.entry_err); end
        press(4'h7, 1'b0, 1'b0);
        press(4'h0, 1'b1, 1'b1);
        checks++; if (kif.entry_err !== 1'b0) begin errors++; $display("FAIL clrent_collect_err got=%b exp=0", kif.entry_err); end
        checks++; if (kif.digit_cnt !== 2'd0) begin errors++; $display("FAIL clrent_cnt got=%0d exp=0", kif.digit_cnt); end
        checks++; if (kif.enter !== 1'b0) begin errors++; $display("FAIL clrent_enter got=%b exp=0", kif.enter); end
    endtask

    task automatic test_idle_enter();
        press(4'h0, 1'b1, 1'b0);
        checks++; if (kif.entry_err !== 1'b1) begin errors++; $display("FAIL idle_enter_err got=%b exp=1", kif.entry_err); end
        checks++; if (kif.enter !== 1'b0) begin errors++; $display("FAIL idle_enter_enter got=%b exp=0", kif.enter); end
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_submit();
        test_short_code();
        test_overflow();
        test_timeout();
        test_lockout();
        test_async_reset();
        test_idle_enter();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_keypad_code_entry
